// File: rtl/hash_update_dispatch_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : hash_update_dispatch_if
// Brief    : Record-in / per-bank-out bundle for the hash-update dispatcher.
// Revision : 1.0
// ============================================================================
interface hash_update_dispatch_if #(
    parameter int DATA_W = 128,
    parameter int BANKS  = 16
);
    logic                    in_valid;
    logic [4:0]              in_bank;
    logic [DATA_W-1:0]       in_data;
    logic                    in_ready;
    logic [BANKS-1:0]        out_valid;
    logic [BANKS*DATA_W-1:0] out_data;
    logic [BANKS-1:0]        out_ready;
    logic [15:0]             bad_bank_cnt;
    logic                    busy;

    modport master (
        output in_valid, in_bank, in_data, out_ready,
        input  in_ready, out_valid, out_data, bad_bank_cnt, busy
    );

    modport slave (
        input  in_valid, in_bank, in_data, out_ready,
        output in_ready, out_valid, out_data, bad_bank_cnt, busy
    );
endinterface
`default_nettype wire

// File: rtl/hash_update_dispatch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : hash_update_dispatch
// Brief    : Routes 128-bit hash-update records to 16 per-bank FIFOs;
//            out-of-range bank indices are dropped and counted.
// Revision : 1.0
// ============================================================================
module hash_update_dispatch #(
    parameter int DATA_W = 128,
    parameter int BANKS  = 16,
    parameter int DEPTH  = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    hash_update_dispatch_if.slave bus
);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    logic [BANKS-1:0]        w_full;
    logic [BANKS-1:0]        w_push;
    logic [BANKS-1:0]        w_pop;
    logic [BANKS-1:0]        w_valid;
    logic [BANKS*DATA_W-1:0] w_data;
    logic                    w_bad_bank;
    logic                    w_in_ready;
    logic [15:0]             r_bad_cnt;

    // Readiness looks only at registered counts, so a same-cycle pop never unblocks a full bank.
    assign w_bad_bank = bus.in_bank[4];
    assign w_in_ready = w_bad_bank | ~w_full[bus.in_bank[3:0]];

    generate
        for (genvar b = 0; b < BANKS; b++) begin : g_bank
            logic [DATA_W-1:0]  r_mem [DEPTH];
            logic [c_PTR_W-1:0] r_wr_ptr;
            logic [c_PTR_W-1:0] r_rd_ptr;
            logic [c_CNT_W-1:0] r_cnt;

            assign w_full[b]  = (r_cnt >= c_DEPTH);
            assign w_valid[b] = (r_cnt != '0);
            assign w_push[b]  = bus.in_valid & w_in_ready & ~w_bad_bank
                              & (bus.in_bank[3:0] == 4'(b));
            assign w_pop[b]   = w_valid[b] & bus.out_ready[b];
            assign w_data[b*DATA_W +: DATA_W] = w_valid[b] ? r_mem[r_rd_ptr] : '0;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_cnt    <= '0;
                end else begin
                    if (w_push[b]) begin
                        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                    end
                    if (w_pop[b]) begin
                        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                    end
                    case ({w_push[b], w_pop[b]})
                        2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
                        2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
                        default: r_cnt <= r_cnt;
                    endcase
                end
            end

            // Storage is left uncleared on reset; out_data masking hides stale entries.
            always_ff @(posedge clk) begin
                if (w_push[b]) begin
                    r_mem[r_wr_ptr] <= bus.in_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bad_cnt <= '0;
        end else if (bus.in_valid && w_bad_bank && (r_bad_cnt != 16'hFFFF)) begin
            r_bad_cnt <= r_bad_cnt + 16'd1;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_valid;
    assign bus.out_data     = w_data;
    assign bus.busy         = |w_valid;
    assign bus.bad_bank_cnt = r_bad_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hash_update_dispatch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_hash_update_dispatch
// Brief    : Directed stimulus with a queue-based scoreboard for the dispatcher.
// Revision : 1.0
// ============================================================================
module tb_hash_update_dispatch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hash_update_dispatch_if #(.DATA_W(128), .BANKS(16)) bus();

    hash_update_dispatch #(.DATA_W(128), .BANKS(16), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]   bank;
        logic [127:0] data;
    } sb_t;

    sb_t sb[$];
    int  n_vec  = 0;
    int  n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [4:0] bank, input logic [127:0] data);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_bank  = bank;
        bus.in_data  = data;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                if (bank < 5'd16) sb.push_back('{bank[3:0], data});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            n_vec++;
            n_fail++;
            $display("FAIL send timeout: bank %0d never accepted", bank);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge clk);
        #1;
        chk("drain leftover", 128'(sb.size()), 128'd0);
    endtask

    // Monitor: every pop is matched against the oldest expected record for that bank.
    always @(negedge clk) begin : mon
        logic [127:0] slice;
        int           idx;
        bit           zbad;
        if (!rst) begin
            zbad = 1'b0;
            for (int b = 0; b < 16; b++) begin
                slice = bus.out_data[b*128 +: 128];
                if (bus.out_valid[b] && bus.out_ready[b]) begin
                    idx = -1;
                    for (int i = 0; i < sb.size(); i++)
                        if (idx < 0 && sb[i].bank == b[3:0]) idx = i;
                    if (idx < 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL pop bank %0d: got %h expected nothing", b, slice);
                    end else begin
                        chk($sformatf("pop bank %0d", b), slice, sb[idx].data);
                        sb.delete(idx);
                    end
                end else if (!bus.out_valid[b] && slice != '0) begin
                    zbad = 1'b1;
                    $display("FAIL idle slice %0d: got %h expected 0", b, slice);
                end
            end
            n_vec++;
            if (zbad) n_fail++;
        end
    end

    logic [4:0]   bads [3];
    logic [15:0]  ev;
    logic [127:0] d;

    initial begin
        bads = '{5'd16, 5'd31, 5'd20};
        bus.in_valid  = 1'b0;
        bus.in_bank   = '0;
        bus.in_data   = '0;
        bus.out_ready = '0;

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst busy", 128'(bus.busy), 128'd0);
        chk("rst bad_cnt", 128'(bus.bad_bank_cnt), 128'd0);
        chk("rst in_ready", 128'(bus.in_ready), 128'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.in_bank = 5'(i);
            @(negedge clk);
            chk($sformatf("idle in_ready bank %0d", i), 128'(bus.in_ready), 128'd1);
            @(posedge clk); #1;
        end
        chk("idle out_valid", 128'(bus.out_valid), 128'd0);

        // Sweep banks 0..15 with all consumers ready
        bus.out_ready = 16'hFFFF;
        for (int b = 0; b < 16; b++) begin
            d = {8'(b), 120'h0};
            bus.in_valid = 1'b1;
            bus.in_bank  = 5'(b);
            bus.in_data  = d;
            ev = (b == 0) ? 16'h0000 : (16'h0001 << (b - 1));
            @(negedge clk);
            chk($sformatf("sweep in_ready %0d", b), 128'(bus.in_ready), 128'd1);
            chk($sformatf("sweep out_valid %0d", b), 128'(bus.out_valid), 128'(ev));
            sb.push_back('{4'(b), d});
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("sweep out_valid last", 128'(bus.out_valid), 128'h8000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("sweep out_valid done", 128'(bus.out_valid), 128'd0);
        chk("sweep busy done", 128'(bus.busy), 128'd0);
        @(posedge clk); #1;

        // Bank 5 full boundary
        bus.out_ready = 16'h0000;
        send(5'd5, 128'hA);
        send(5'd5, 128'hB);
        bus.in_valid = 1'b1;
        bus.in_bank  = 5'd5;
        bus.in_data  = 128'hC;
        @(negedge clk);
        chk("full in_ready", 128'(bus.in_ready), 128'd0);
        chk("full busy", 128'(bus.busy), 128'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("full in_ready hold", 128'(bus.in_ready), 128'd0);
        @(posedge clk); #1;
        bus.out_ready[5] = 1'b1;
        @(negedge clk);
        chk("full in_ready same-cycle pop", 128'(bus.in_ready), 128'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("full in_ready after pop", 128'(bus.in_ready), 128'd1);
        sb.push_back('{4'd5, 128'hC});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        drain();

        // Out-of-range banks
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_bank  = bads[i];
            bus.in_data  = 128'hDEAD;
            @(negedge clk);
            chk($sformatf("bad in_ready %0d", bads[i]), 128'(bus.in_ready), 128'd1);
            chk($sformatf("bad out_valid %0d", bads[i]), 128'(bus.out_valid), 128'd0);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bad_cnt 3", 128'(bus.bad_bank_cnt), 128'd3);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_bank  = 5'd31;
        repeat (65531) @(posedge clk);
        #1;
        @(negedge clk);
        chk("bad_cnt FFFE", 128'(bus.bad_bank_cnt), 128'hFFFE);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bad_cnt FFFF", 128'(bus.bad_bank_cnt), 128'hFFFF);
        repeat (5) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bad_cnt saturated", 128'(bus.bad_bank_cnt), 128'hFFFF);
        chk("bad out_valid none", 128'(bus.out_valid), 128'd0);
        @(posedge clk); #1;

        // Bank 9: simultaneous push/pop, then pointer wrap
        bus.out_ready = 16'h0000;
        send(5'd9, 128'h9_0000);
        bus.out_ready[9] = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_bank  = 5'd9;
        bus.in_data  = 128'h9_0001;
        @(negedge clk);
        chk("pushpop in_ready", 128'(bus.in_ready), 128'd1);
        sb.push_back('{4'd9, 128'h9_0001});
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 16'h0000;
        @(negedge clk);
        chk("pushpop out_valid", 128'(bus.out_valid), 128'h0200);
        chk("pushpop head", bus.out_data[9*128 +: 128], 128'h9_0001);
        @(posedge clk); #1;
        bus.out_ready[9] = 1'b1;
        for (int k = 2; k < 12; k++) send(5'd9, 128'h9_0000 + 128'(k));
        drain();
        @(negedge clk);
        chk("wrap out_valid empty", 128'(bus.out_valid), 128'd0);
        @(posedge clk); #1;

        // Reset with banks 3 and 12 partially filled
        bus.out_ready = 16'h0000;
        send(5'd3, 128'h3333);
        send(5'd12, 128'hCCCC);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst out_valid", 128'(bus.out_valid), 128'd0);
        chk("midrst busy", 128'(bus.busy), 128'd0);
        @(posedge clk); #1;
        send(5'd3, 128'h3_F00D);
        @(negedge clk);
        chk("fresh out_valid", 128'(bus.out_valid), 128'h0008);
        chk("fresh data", bus.out_data[3*128 +: 128], 128'h3_F00D);
        @(posedge clk); #1;
        bus.out_ready = 16'hFFFF;
        drain();
        @(negedge clk);
        chk("final busy", 128'(bus.busy), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hash_update_dispatch.md
# hash_update_dispatch

Routes a stream of 128-bit hash-update records to one of 16 hash-bank write ports, selected by a 5-bit bank index. It is the distribution side of the 16-to-1 hash-update selection path. Each bank has a small FIFO with valid/ready drain, so a stalled bank back-pressures only records aimed at it. Out-of-range indices are consumed, dropped and counted.

## Interface
Parameters:
- DATA_W, 128, record width
- BANKS, 16, number of bank ports; fixed at 16, so the index is 5 bits
- DEPTH, 2, per-bank FIFO entries; power of two, ≥2

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  record offered
- in_bank  in  5  target bank; 0..15 valid, 16..31 invalid
- in_data  in  DATA_W  record payload
- in_ready  out  1  record accepted when in_valid & in_ready
- out_valid  out  BANKS  bit b: bank b head entry valid
- out_data  out  BANKS*DATA_W  bank b payload at bits [b*DATA_W +: DATA_W]
- out_ready  in  BANKS  bit b: bank b consumes its head this cycle
- bad_bank_cnt  out  16  count of dropped records with in_bank ≥ 16; saturating
- busy  out  1  any bank FIFO non-empty

## Operation
- in_ready is combinational from in_bank and the registered FIFO counts:
  - 1 if in_bank ≥ 16
  - else 1 iff count[in_bank] < DEPTH
- in_ready has no path from out_ready. A full bank stays blocked for the cycle even if it is popped in that cycle.
- Source rule: while in_valid=1 and the record is not accepted, in_bank and in_data must be held stable.
- Accept with in_bank < 16: payload is written at wr_ptr[in_bank]; wr_ptr and count increment.
- Accept with in_bank ≥ 16: payload is discarded; bad_bank_cnt increments, saturating at 0xFFFF.
- Pop on bank b (out_valid[b] & out_ready[b]): rd_ptr[b] increments and count[b] decrements. out_ready[b] while empty is ignored.
- Push and pop on the same bank in the same cycle: count unchanged, both pointers advance. This is legal whenever count was 1..DEPTH-1.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Ordering: records to one bank leave in acceptance order. There is no ordering guarantee across banks.
- out_valid[b] = (count[b] != 0).
- out_data slice b = entry at rd_ptr[b] when valid; forced to 0 when out_valid[b]=0.
- busy = OR of all out_valid bits.
- No state machine beyond the 16 independent FIFO controllers and the drop counter.

## Timing
- Reset (rst=1 at an edge) sets all counts, pointers and bad_bank_cnt to 0. FIFO contents need not be cleared.
- Outputs during and after reset: out_valid=0, out_data=0, busy=0, bad_bank_cnt=0. in_ready follows its rule, so it is 1.
- Reset mid-operation: all buffered records are discarded, no pop completes in the reset cycle, and an in-flight accept is lost.
- Latency: a record accepted at edge N shows on out_valid/out_data after edge N; a consumer with out_ready=1 pops it at edge N+1.
- Throughput: one record accepted per cycle. Each bank sustains one pop per cycle. With DEPTH ≥ 2, a single bank with out_ready held high sustains full rate.
- Full boundary: with count=DEPTH, in_ready=0 for that bank until the cycle after a pop.
- Empty boundary: with count=0, out_valid=0; a push makes it 1 next cycle.
- bad_bank_cnt at 0xFFFF stays at 0xFFFF on further drops.

## Test plan
- Reset then idle → out_valid=0x0000, busy=0, bad_bank_cnt=0, in_ready=1 for all in_bank values.
- Send banks 0..15, one per cycle, data = {bank, 120'h0}, out_ready=0xFFFF → each out_valid[b] pulses for one cycle, one cycle after its accept, with the matching payload; all other slices read 0.
- Bank 5, out_ready[5]=0, send A, B, C → A and B accepted, in_ready=0 while offering C. Raise out_ready[5] → A pops, C is accepted one cycle later, drain order A, B, C.
- in_bank=16, 31, 20 with in_valid held for 3 cycles → in_ready=1, bad_bank_cnt=3, no out_valid bits set. Force 65540 drops → bad_bank_cnt=0xFFFF.
- Bank 9 holding 1 entry, simultaneous push of D and pop of the head → count stays 1 and D becomes head next cycle. Wrap test: 10 push/pop cycles on bank 9 → data order preserved across pointer wrap.
- Banks 3 and 12 half full, assert rst for one cycle → next cycle out_valid=0, busy=0. A fresh record to bank 3 appears alone, with no stale data.
